// File: rtl/aes_round_ctrl_wddl.sv
// aes_round_ctrl_wddl
// Round sequencer for a WDDL (dual-rail precharge) AES datapath. Every
// operation alternates a precharge cycle (pre, both rails low) and an evaluate
// cycle (eval). One load pair (text_in ^ key) is followed by NR round pairs,
// and the block then waits in DONE until the consumer acknowledges it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin one block (honoured only while ready=1)
//   abort      terminate the current block; returns to IDLE with round=0
//   out_ack    consumer acknowledge of the finished block (honoured in DONE)
//   ready      controller idle and able to accept start
//   ld_r       state-register load select: text_in^key (1) vs. round path (0)
//   pre        WDDL precharge phase
//   eval       WDDL evaluate phase
//   kx_en      advance the key schedule by one round key
//   round      current round index, 0..NR
//   last_round final round (MixColumns bypassed)
//   done       state register holds the completed ciphertext
//
// All outputs are flops, loaded from the next-state values, so no input
// reaches an output combinationally.
module aes_round_ctrl_wddl #(
  parameter int NR = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       out_ack,
  output logic       ready,
  output logic       ld_r,
  output logic       pre,
  output logic       eval,
  output logic       kx_en,
  output logic [3:0] round,
  output logic       last_round,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_PRE   = 3'd1,
    LD_EVAL  = 3'd2,
    RND_PRE  = 3'd3,
    RND_EVAL = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [3:0] NR_L = 4'(NR);

  state_t     state;
  state_t     nxt_state;
  logic       armed;
  logic       nxt_armed;
  logic [3:0] nxt_round;

  // A start sampled in IDLE first sets 'armed' (ready drops, further starts
  // are ignored); the following edge enters LD_PRE. This keeps the first
  // evaluate aligned to the datapath's registered text_in/key inputs and
  // gives done on edge 2*NR+3 after start was sampled.
  always_comb begin
    nxt_state = state;
    nxt_armed = armed;
    nxt_round = round;
    if (state != IDLE && abort) begin
      nxt_state = IDLE;
      nxt_armed = 1'b0;
      nxt_round = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_round = '0;
          if (abort) begin
            nxt_armed = 1'b0;
          end else if (armed) begin
            nxt_state = LD_PRE;
            nxt_armed = 1'b0;
          end else if (start) begin
            nxt_armed = 1'b1;
          end
        end
        LD_PRE: begin
          nxt_state = LD_EVAL;
          nxt_round = '0;
        end
        LD_EVAL: begin
          nxt_state = RND_PRE;
          nxt_round = 4'd1;
        end
        RND_PRE: begin
          nxt_state = RND_EVAL;
        end
        RND_EVAL: begin
          if (round < NR_L) begin
            nxt_state = RND_PRE;
            nxt_round = round + 4'd1;
          end else begin
            nxt_state = DONE;
            nxt_round = NR_L;
          end
        end
        DONE: begin
          nxt_round = NR_L;
          if (out_ack) begin
            nxt_state = IDLE;
            nxt_round = '0;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_armed = 1'b0;
          nxt_round = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      armed      <= 1'b0;
      round      <= '0;
      ready      <= 1'b1;
      ld_r       <= 1'b0;
      pre        <= 1'b0;
      eval       <= 1'b0;
      kx_en      <= 1'b0;
      last_round <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt_state;
      armed      <= nxt_armed;
      round      <= nxt_round;
      ready      <= (nxt_state == IDLE) && !nxt_armed;
      ld_r       <= (nxt_state == LD_EVAL);
      pre        <= (nxt_state == LD_PRE) || (nxt_state == RND_PRE);
      eval       <= (nxt_state == LD_EVAL) || (nxt_state == RND_EVAL);
      kx_en      <= (nxt_state == RND_EVAL);
      last_round <= ((nxt_state == RND_PRE) || (nxt_state == RND_EVAL)) &&
                    (nxt_round == NR_L);
      done       <= (nxt_state == DONE);
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl_wddl.sv
// Testbench for aes_round_ctrl_wddl. A phase-counter reference model predicts
// every cycle's output vector and each block's done edge; a monitor pops and
// compares. A second instance built with NR=14 checks the long-key latency.
module tb_aes_round_ctrl_wddl;

  localparam int NR      = 10;
  localparam int DONE_PH = 2 * NR + 3;
  localparam logic [10:0] RESET_VEC = 11'b100_0000_0000;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, out_ack;
  logic       ready, ld_r, pre, eval, kx_en, last_round, done;
  logic [3:0] round;
  logic       start14, abort14, out_ack14;
  logic       ready14, ld_r14, pre14, eval14, kx_en14, last_round14, done14;
  logic [3:0] round14;
  logic [10:0] dut_vec;

  always #5 clk = ~clk;

  aes_round_ctrl_wddl #(.NR(NR)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ack(out_ack),
    .ready(ready), .ld_r(ld_r), .pre(pre), .eval(eval), .kx_en(kx_en),
    .round(round), .last_round(last_round), .done(done)
  );

  aes_round_ctrl_wddl #(.NR(14)) u_dut14 (
    .clk(clk), .rst_n(rst_n), .start(start14), .abort(abort14), .out_ack(out_ack14),
    .ready(ready14), .ld_r(ld_r14), .pre(pre14), .eval(eval14), .kx_en(kx_en14),
    .round(round14), .last_round(last_round14), .done(done14)
  );

  assign dut_vec = {ready, ld_r, pre, eval, kx_en, last_round, done, round};

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int m_phase = 0;      // 0 idle, 1 load-pre, 2 load-eval, 3..2NR+2 rounds, 2NR+3 done
  bit m_armed = 1'b0;   // start accepted, block begins at the next edge
  bit m_pending = 1'b0; // block accepted but done not yet predicted
  logic [10:0] exp_q[$];
  int blk_q[$];         // expected edge number at which done first shows
  int kx_cnt = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the block phase: load pair, then NR pre/eval pairs
  // with round k occupying phases 2k+1 and 2k+2, then done.
  function automatic logic [10:0] exp_vec(input int ph, input bit arm);
    bit rnd;
    int r;
    logic [3:0] r4;
    rnd = (ph >= 3) && (ph <= 2 * NR + 2);
    r = (ph <= 2) ? 0 : ((ph >= DONE_PH) ? NR : (ph - 1) / 2);
    r4 = 4'(r);
    return {(ph == 0) && !arm,
            ph == 2,
            (ph == 1) || (rnd && (ph % 2 == 1)),
            (ph == 2) || (rnd && (ph % 2 == 0)),
            rnd && (ph % 2 == 0),
            rnd && (r == NR),
            ph == DONE_PH,
            r4};
  endfunction

  task automatic cancel_pending();
    if (m_pending) begin
      void'(blk_q.pop_back());
      m_pending = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      m_phase = 0;
      m_armed = 1'b0;
      cancel_pending();
    end else if (m_phase != 0 && abort) begin
      m_phase = 0;
      m_armed = 1'b0;
      cancel_pending();
    end else if (m_phase == 0) begin
      if (abort) begin
        m_armed = 1'b0;
        cancel_pending();
      end else if (m_armed) begin
        m_phase = 1;
        m_armed = 1'b0;
      end else if (start) begin
        m_armed = 1'b1;
        m_pending = 1'b1;
        blk_q.push_back(edge_n + DONE_PH);
      end
    end else if (m_phase == DONE_PH) begin
      if (out_ack) m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase == DONE_PH) m_pending = 1'b0;
    end
    exp_q.push_back(exp_vec(m_phase, m_armed));
  end

  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL outputs: no expected vector queued, actual=%0h", dut_vec);
    end else begin
      chk("outputs", int'(dut_vec), int'(exp_q.pop_front()));
    end
    if (ld_r) kx_cnt = 0;
    if (kx_en) kx_cnt++;
    if (done && !prev_done) begin
      if (blk_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_unexpected: actual done=1 at edge %0d required no block", edge_n);
      end else begin
        chk("done_edge", edge_n, blk_q.pop_front());
        chk("kx_pulses", kx_cnt, NR);
      end
    end
    prev_done = done;
  end

  // Called at a negedge with the model idle; returns at a negedge, idle again.
  task automatic run_block(input bit hold, input int abort_pt, input int ack_dly,
                           input bit noise, input bit start_in_done);
    int guard;
    int dcnt;
    bit busy;
    start = 1'b1;
    abort = 1'b0;
    out_ack = 1'b0;
    busy = 1'b0;
    dcnt = 0;
    guard = 0;
    while (guard < 300) begin
      @(negedge clk);
      guard++;
      if (m_phase != 0 || m_armed) busy = 1'b1;
      else if (busy) break;
      start = hold;
      abort = (abort_pt != 0) && (m_phase == abort_pt);
      if (m_phase == DONE_PH) begin
        out_ack = (dcnt >= ack_dly);
        if (start_in_done) start = 1'b1;
        dcnt++;
      end else begin
        out_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    if (guard >= 300) begin
      n_cmp++;
      n_bad++;
      $display("FAIL block_timeout: actual %0d cycles required fewer than 300", guard);
    end
    start = 1'b0;
    abort = 1'b0;
    out_ack = 1'b0;
  endtask

  initial begin
    int g;
    int n;
    int kx;
    start = 1'b0; abort = 1'b0; out_ack = 1'b0;
    start14 = 1'b0; abort14 = 1'b0; out_ack14 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_vec", int'(dut_vec), int'(RESET_VEC));
    chk("reset_vec_nr14", int'({ready14, ld_r14, pre14, eval14, kx_en14, last_round14, done14, round14}),
        int'(RESET_VEC));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_block(1'b0, 0, 5, 1'b0, 1'b0);          // single pulse, ack after 5 DONE cycles
    run_block(1'b0, 12, 0, 1'b0, 1'b0);         // abort in RND_EVAL, round 5
    run_block(1'b0, 0, 0, 1'b0, 1'b0);          // normal block after abort
    run_block(1'b1, 0, 2, 1'b0, 1'b1);          // start held, start with ack in DONE
    run_block(1'b0, DONE_PH, 3, 1'b1, 1'b0);    // abort in DONE, stray acks earlier

    start = 1'b1; abort = 1'b1;                  // abort with start in IDLE
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_ready", int'(ready), 1);
    start = 1'b1;                                // abort during the armed cycle
    @(negedge clk);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);

    start = 1'b1;                                // async reset inside RND_PRE
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (m_phase != 9 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("reach_rnd_pre", m_phase, 9);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_mid_block", int'(dut_vec), int'(RESET_VEC));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_block(1'b0, 0, 1, 1'b0, 1'b0);          // fresh block after reset

    for (int i = 0; i < 10; i++) begin
      int ap;
      ap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, DONE_PH)) : 0;
      run_block(1'($urandom_range(0, 1)), ap, int'($urandom_range(0, 6)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    start14 = 1'b1;
    @(negedge clk);
    start14 = 1'b0;
    n = 0;
    kx = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (kx_en14) kx++;
      if (done14) break;
    end
    chk("nr14_done_edge", n, 31);
    chk("nr14_kx_pulses", kx, 14);
    @(negedge clk);
    out_ack14 = 1'b1;
    @(negedge clk);
    out_ack14 = 1'b0;
    chk("nr14_ready_after_ack", int'(ready14), 1);

    repeat (3) @(negedge clk);
    chk("blocks_outstanding", blk_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl_wddl.md
AES_ROUND_CTRL_WDDL -- requirements
Module: aes_round_ctrl_wddl

Interface
REQ-001 Parameter NR, default 10, SHALL set the number of cipher rounds; legal values are 10, 12 and 14.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be the request to begin one block operation.
REQ-005 abort  input  1  SHALL be the request to terminate the current operation.
REQ-006 out_ack  input  1  SHALL be the consumer acknowledge for a completed block.
REQ-007 ready  output  1  SHALL indicate that start is accepted this cycle.
REQ-008 ld_r  output  1  SHALL be the load select for the addroundkey state registers (text_in^key vs. round path).
REQ-009 pre  output  1  SHALL be the WDDL precharge phase flag, forcing both rails low.
REQ-010 eval  output  1  SHALL be the WDDL evaluate phase flag.
REQ-011 kx_en  output  1  SHALL advance the key schedule by one round key.
REQ-012 round  output  4  SHALL be the current round index.
REQ-013 last_round  output  1  SHALL mark the final round, in which MixColumns is bypassed.
REQ-014 done  output  1  SHALL indicate that the state register holds the completed ciphertext.

Function
REQ-015 All outputs SHALL be driven directly from flops: no combinational path from any input to any output.
REQ-016 The FSM SHALL have exactly six states: IDLE, LD_PRE, LD_EVAL, RND_PRE, RND_EVAL and DONE.
REQ-017 In IDLE, ready SHALL be 1; start=1 SHALL move the FSM to LD_PRE. In every other state, ready SHALL be 0 and start SHALL be ignored.
REQ-018 LD_PRE SHALL assert pre=1 with round=0 and SHALL go to LD_EVAL unconditionally.
REQ-019 LD_EVAL SHALL assert eval=1, ld_r=1 and round=0, and SHALL go to RND_PRE with round incremented to 1.
REQ-020 RND_PRE SHALL assert pre=1 and ld_r=0, and SHALL go to RND_EVAL.
REQ-021 RND_EVAL SHALL assert eval=1 and kx_en=1. If round<NR, it SHALL go to RND_PRE with round+1; if round==NR, it SHALL go to DONE.
REQ-022 last_round SHALL be 1 exactly while round==NR in RND_PRE or RND_EVAL, and 0 otherwise.
REQ-023 DONE SHALL assert done=1 and hold round=NR. done SHALL stay at 1 until out_ack=1 is sampled, and the FSM SHALL then return to IDLE.
REQ-024 pre and eval SHALL never both be 1. Both SHALL be 0 in IDLE and DONE. No two consecutive eval cycles SHALL occur.
REQ-025 ld_r SHALL be 1 only in LD_EVAL; kx_en SHALL be 1 only in RND_EVAL.
REQ-026 Latency: with start sampled at edge 0, done SHALL first be 1 after edge 2*NR+3 (edge 23 for NR=10). kx_en SHALL pulse exactly NR times per block.
REQ-027 abort=1 in any state except IDLE SHALL force the FSM to IDLE at the next edge with round=0. abort SHALL take priority over out_ack and over round advance.
REQ-028 abort=1 in IDLE with start=1 SHALL leave the FSM in IDLE.
REQ-029 out_ack outside DONE SHALL be ignored. start and out_ack both 1 in DONE SHALL return the FSM to IDLE only, with no new block started.
REQ-030 The round counter SHALL never exceed NR and SHALL never wrap.
REQ-031 Any unreachable state encoding SHALL recover to IDLE at the next edge.

Reset
REQ-032 While rst_n=0, the FSM SHALL be in IDLE with ready=1, and ld_r, pre, eval, kx_en, last_round and done SHALL all be 0, with round=0. This SHALL take effect immediately, without waiting for a clock edge.
REQ-033 Reset asserted mid-block SHALL discard the operation. After rst_n is released, the first start SHALL begin a fresh sequence from LD_PRE.

Verification
REQ-034 Reset, then start pulse for 1 cycle (NR=10) -> ld_r=1 for exactly 1 cycle (cycle 2); pre/eval alternate; kx_en pulses 10 times; last_round=1 for cycles 21-22; done=1 from cycle 23.
REQ-035 Hold out_ack=0 for 5 cycles in DONE, then pulse it -> done holds for all 5 cycles; IDLE with ready=1 on the next cycle.
REQ-036 Assert abort at round=5 in RND_EVAL -> next cycle IDLE with round=0 and done never asserted; a following start completes normally.
REQ-037 Assert start continuously throughout a block, and start with out_ack in DONE -> exactly one block is run per IDLE entry; no restart from DONE.
REQ-038 Drop rst_n asynchronously mid-RND_PRE (between clock edges) -> all outputs reach reset values before the next edge.
REQ-039 NR=14 build -> done first 1 after edge 31, with 14 kx_en pulses.
